edge_period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous input signal against the 100 MHz system clock. It is the receiving counterpart of the clock-divider/counter blocks: a divider turns clk into a slow toggle, and this block turns a slow toggle back into cycle counts. It also keeps a 4-bit rising-edge counter and flags loss of signal with a timeout. It sits between external or divided-clock sources and downstream display/check logic.

---
 rtl/edge_period_meter.sv | 149 ++++++++++++++
 tb/tb_edge_period_meter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_period_meter.sv
// edge_period_meter
// Measures the period and high time of a slow asynchronous input in system
// clock cycles. It also counts rising edges modulo 16 and raises a sticky
// loss-of-signal flag when no rising edge arrives within TIMEOUT cycles.
//
// Handshake: meas_valid is a one-cycle qualifier with no ready. In the cycle
// it is high, period_out/high_out hold the newest measurement. Consumers must
// sample them in that cycle, or accept that a later measurement may overwrite
// them. Between pulses, period_out/high_out hold their last values.
module edge_period_meter #(
    parameter int unsigned      CNT_W   = 26,
    parameter logic [CNT_W-1:0] TIMEOUT = 26'd50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout,
    output logic [3:0]       edge_count,
    output logic             dbg_state    // 0 = IDLE, 1 = MEASURE
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_s1;
    logic             r_s2;
    logic             r_sig_d;
    logic             w_rise;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_hcnt_next;
    logic             w_capture;
    logic             w_lost;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_timeout;
    logic [3:0]       r_edges;

    // Two-flop synchronizer plus one delay stage for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_sig_d <= 1'b0;
        end else begin
            r_s1    <= sig_in;
            r_s2    <= r_s1;
            r_sig_d <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_sig_d;

    // FSM state and measurement counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_hcnt  <= w_hcnt_next;
        end
    end

    // Next state and counter values. A rise always takes priority over the
    // timeout, so an edge landing exactly at TIMEOUT is a valid measurement.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hcnt_next  = r_hcnt;
        w_capture    = 1'b0;
        w_lost       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next  = '0;
                w_hcnt_next = '0;
                if (w_rise) begin
                    w_cnt_next   = ONE;
                    w_hcnt_next  = ONE;
                    w_state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (w_rise) begin
                    w_capture   = 1'b1;
                    w_cnt_next  = ONE;
                    w_hcnt_next = ONE;
                end else if (r_cnt == TIMEOUT) begin
                    w_lost       = 1'b1;
                    w_cnt_next   = '0;
                    w_hcnt_next  = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + ONE;
                    if (r_s2) begin
                        w_hcnt_next = r_hcnt + ONE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output registers: capture on a measuring rise, sticky timeout, edge count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_edges   <= 4'd0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_period  <= r_cnt;
                r_high    <= r_hcnt;
                r_timeout <= 1'b0;
            end else if (w_lost) begin
                r_timeout <= 1'b1;
            end
            if (w_rise) begin
                r_edges <= r_edges + 4'd1;
            end
        end
    end

    assign period_out = r_period;
    assign high_out   = r_high;
    assign meas_valid = r_valid;
    assign timeout    = r_timeout;
    assign edge_count = r_edges;
    assign dbg_state  = (r_state == ST_MEASURE);

endmodule

// File: tb/tb_edge_period_meter.sv
// Bench for edge_period_meter with TIMEOUT = 1000.
// A cycle-level reference model tracks rise times and high-cycle totals as
// plain integers. Table-driven square waves, directed corner sequences and
// random waveforms run against it.
module tb_edge_period_meter;

    localparam int CNT_W = 26;
    localparam int TO    = 1000;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;
    logic             timeout;
    logic [3:0]       edge_count;
    logic             dbg_state;

    always #5 clk = ~clk;

    edge_period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (26'd1000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .edge_count (edge_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // seen[0] is the sig_in value taken at the previous edge, seen[1] the one
    // before that. A rise counts two edges after the input was first seen high.
    bit seen [3];
    int cyc      = 0;
    bit armed    = 1'b0;
    int t_last   = 0;
    int high_acc = 0;
    int e_period = 0;
    int e_high   = 0;
    bit e_valid  = 1'b0;
    bit e_to     = 1'b0;
    int e_edges  = 0;

    always @(posedge clk) begin
        bit rise;
        cyc++;
        if (rst) begin
            seen     = '{1'b0, 1'b0, 1'b0};
            armed    = 1'b0;
            e_period = 0;
            e_high   = 0;
            e_valid  = 1'b0;
            e_to     = 1'b0;
            e_edges  = 0;
            high_acc = 0;
        end else begin
            rise    = seen[1] & ~seen[2];
            e_valid = 1'b0;
            if (rise) begin
                e_edges = (e_edges + 1) % 16;
                if (armed) begin
                    e_period = cyc - t_last;
                    e_high   = high_acc;
                    e_valid  = 1'b1;
                    e_to     = 1'b0;
                end
                armed    = 1'b1;
                t_last   = cyc;
                high_acc = 1;
            end else if (armed) begin
                if (cyc - t_last == TO) begin
                    e_to  = 1'b1;
                    armed = 1'b0;
                end else if (seen[1]) begin
                    high_acc++;
                end
            end
            seen[2] = seen[1];
            seen[1] = seen[0];
            seen[0] = sig_in;
        end
    end

    // ---------------- scoreboard: continuous model compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_period", 64'(period_out), 64'(e_period));
            check("mdl_high",   64'(high_out),   64'(e_high));
            check("mdl_valid",  64'(meas_valid), 64'(e_valid));
            check("mdl_timeout",64'(timeout),    64'(e_to));
            check("mdl_edges",  64'(edge_count), 64'(e_edges));
            check("mdl_state",  64'(dbg_state),  64'(armed));
        end
    end

    // Expected queue of observed measurements, used by the table checks.
    logic [CNT_W-1:0] vp_q[$];
    logic [CNT_W-1:0] vh_q[$];
    int               vt_q[$];
    int               ncyc = 0;

    always @(negedge clk) begin
        ncyc++;
        if (chk_en && meas_valid === 1'b1) begin
            vp_q.push_back(period_out);
            vh_q.push_back(high_out);
            vt_q.push_back(ncyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic hold(input logic level, input int n);
        sig_in = level;
        repeat (n) @(negedge clk);
    endtask

    // Raise sig_in and look at the outputs two edges after the first edge
    // that samples it high; a negative exp_edges skips the edge-count check.
    task automatic rise_check(input string tag, input logic exp_v, input int exp_edges,
                              input int exp_p, input int exp_h, input logic exp_to);
        sig_in = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_valid"},   64'(meas_valid), 64'(exp_v));
        check({tag, "_timeout"}, 64'(timeout),    64'(exp_to));
        if (exp_edges >= 0) check({tag, "_edges"}, 64'(edge_count), 64'(exp_edges));
        if (exp_v) begin
            check({tag, "_period"}, 64'(period_out), 64'(exp_p));
            check({tag, "_high"},   64'(high_out),   64'(exp_h));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"},  64'(period_out), 64'd0);
        check({tag, "_high"},    64'(high_out),   64'd0);
        check({tag, "_valid"},   64'(meas_valid), 64'd0);
        check({tag, "_timeout"}, 64'(timeout),    64'd0);
        check({tag, "_edges"},   64'(edge_count), 64'd0);
        check({tag, "_state"},   64'(dbg_state),  64'd0);
    endtask

    typedef struct {
        int hi;
        int lo;
        int n;
        int exp_p;
        int exp_h;
    } vec_t;

    vec_t vecs [6];

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int hi;
        int lo;

        vecs[0] = '{hi: 30,  lo: 70,  n: 5, exp_p: 100, exp_h: 30};
        vecs[1] = '{hi: 1,   lo: 1,   n: 6, exp_p: 2,   exp_h: 1};
        vecs[2] = '{hi: 7,   lo: 3,   n: 6, exp_p: 10,  exp_h: 7};
        vecs[3] = '{hi: 2,   lo: 5,   n: 5, exp_p: 7,   exp_h: 2};
        vecs[4] = '{hi: 400, lo: 590, n: 2, exp_p: 990, exp_h: 400};
        vecs[5] = '{hi: 1,   lo: 2,   n: 4, exp_p: 3,   exp_h: 1};

        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst    = 1'b0;
        chk_en = 1'b1;

        // 50/50 square wave: first rise only arms, second measures.
        rise_check("sq50_r1", 1'b0, 1, 0, 0, 1'b0);
        hold(1'b1, 47);
        hold(1'b0, 50);
        rise_check("sq50_r2", 1'b1, 2, 100, 50, 1'b0);
        hold(1'b1, 47);
        hold(1'b0, 50);

        // Table of square waves: n+1 rises give n+1 measurements; the last n
        // must match the table and be spaced exactly one period apart.
        for (int i = 0; i < 6; i++) begin
            base = vp_q.size();
            for (int p = 0; p <= vecs[i].n; p++) begin
                hold(1'b1, vecs[i].hi);
                hold(1'b0, vecs[i].lo);
            end
            hold(1'b0, 4);
            check($sformatf("tbl%0d_count", i), 64'(vp_q.size() - base), 64'(vecs[i].n + 1));
            for (int k = base + 1; k < vp_q.size(); k++) begin
                check($sformatf("tbl%0d_period", i), 64'(vp_q[k]), 64'(vecs[i].exp_p));
                check($sformatf("tbl%0d_high", i),   64'(vh_q[k]), 64'(vecs[i].exp_h));
                if (k > base + 1)
                    check($sformatf("tbl%0d_spacing", i), 64'(vt_q[k] - vt_q[k-1]), 64'(vecs[i].exp_p));
            end
        end

        // Loss of signal: timeout exactly TO cycles after the last rise.
        hold(1'b1, 50);
        hold(1'b0, 50);
        hold(1'b1, 50);
        hold(1'b0, 50);
        rise_check("to_last", 1'b1, -1, 100, 50, 1'b0);
        hold(1'b1, 47);
        hold(1'b0, TO - 48);
        check("to_before", 64'(timeout), 64'd0);
        hold(1'b0, 1);
        check("to_set", 64'(timeout), 64'd1);
        check("to_period_kept", 64'(period_out), 64'd100);
        check("to_high_kept", 64'(high_out), 64'd50);
        rise_check("to_rearm", 1'b0, -1, 0, 0, 1'b1);
        hold(1'b1, 47);
        hold(1'b0, 50);
        rise_check("to_clear", 1'b1, -1, 100, 50, 1'b0);
        hold(1'b1, 47);
        hold(1'b0, 50);

        // Rises exactly TO apart: the rise wins over the timeout.
        hold(1'b1, 500);
        hold(1'b0, 500);
        rise_check("exact1", 1'b1, -1, TO, 500, 1'b0);
        hold(1'b1, 497);
        hold(1'b0, 500);
        rise_check("exact2", 1'b1, -1, TO, 500, 1'b0);
        hold(1'b1, 47);
        hold(1'b0, 50);

        // 17 rises from reset: edge_count wraps through 0 to 1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            hold(1'b1, 3);
            hold(1'b0, 3);
        end
        hold(1'b0, 3);
        check("wrap17_edges", 64'(edge_count), 64'd1);

        // Reset in mid-high phase: everything clears, the still-high input
        // then produces a first (arming) rise and the next rise measures.
        hold(1'b1, 10);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_r1_edges", 64'(edge_count), 64'd1);
        check("midrst_r1_valid", 64'(meas_valid), 64'd0);
        hold(1'b1, 37);
        hold(1'b0, 50);
        rise_check("midrst_r2", 1'b1, 2, 90, 40, 1'b0);
        hold(1'b1, 37);
        hold(1'b0, 50);

        // Random waveforms, including gaps around TO and occasional resets.
        for (int i = 0; i < 150; i++) begin
            hi = $urandom_range(1, 60);
            lo = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 60, TO + 10)
                                              : $urandom_range(1, 60);
            hold(1'b1, hi);
            hold(1'b0, lo);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        hold(1'b0, 5);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
